apb4_regfile_slave: RTL

Parametrised APB4 completer that generalises the team's fixed 10-bit/32-bit APB interface. It adds configurable address/data width, register count, programmable wait states, PSTRB byte-lane writes and PSLVERR error signalling. The block sits behind the APB interconnect and exposes a flat register file to hardware logic. Registers flagged read-only return live hardware status.

---
 rtl/apb4_pkg.sv | 28 ++
 rtl/apb4_wait_ctr.sv | 23 ++
 rtl/apb4_regfile_slave.sv | 108 ++++++++++
 3 files changed

// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 completer family.
// strb_merge and addr_to_idx work on 64-bit words so any legal DATA_W fits.
package apb4_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [63:0] strb_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                              input int unsigned data_w);
    return addr >> $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// Loadable down-counter for APB wait-state insertion; saturates at zero.
module apb4_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (en && cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb4_regfile_slave.sv
// Parametrised APB4 completer exposing a flat register file with byte strobes,
// programmable wait states, read-only status registers and PSLVERR.
//   state  | meaning
//   IDLE   | no transfer in progress; waits for a setup phase
//   ACCESS | setup seen; counting wait states, completes when counter is zero
module apb4_regfile_slave
  import apb4_pkg::*;
#(
  parameter int                  ADDR_W      = 10,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t              state_q, state_d;
  logic                ctr_load, ctr_en, ctr_zero;
  logic                complete, valid, ro, wr_ok;
  logic [ADDR_W-1:0]   idx;
  logic [IDX_W-1:0]    sel;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  assign idx    = ADDR_W'(addr_to_idx(64'(paddr), DATA_W));
  assign sel    = idx[IDX_W-1:0];
  assign valid  = (32'(idx) < 32'(NUM_REGS));
  assign ro     = valid & RO_MASK[sel];
  assign merged = DATA_W'(strb_merge(64'(regs_q[sel]), 64'(pwdata), 8'(pstrb)));

  apb4_wait_ctr #(.W(WAIT_CNT_W)) u_wait (
    .clk      (pclk),
    .rst      (preset),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (WAIT_CNT_W'(WAIT_STATES)),
    .zero     (ctr_zero)
  );

  // A PSEL&PENABLE without a preceding setup is ignored in IDLE.
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d  = ACCESS;
          ctr_load = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel)          state_d = IDLE;
        else if (!ctr_zero) ctr_en  = 1'b1;
        else if (penable)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign complete = (state_q == ACCESS) & psel & penable & ctr_zero;
  assign pready   = complete;
  assign pslverr  = complete & (~valid | (pwrite & ro));
  assign wr_ok    = complete & pwrite & valid & ~ro;

  always_comb begin
    prdata = '0;
    if (complete && !pwrite && valid)
      prdata = ro ? hw_status_i[sel*DATA_W +: DATA_W] : regs_q[sel];
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      wr_pulse_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      wr_pulse_o <= '0;
      if (wr_ok) begin
        regs_q[sel]     <= merged;
        wr_pulse_o[sel] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule
